fifo_wr_ptr_ctrl: RTL and testbench

Write-side pointer and flag controller for the asynchronous FIFO, in the wr_clk domain.
- Generates the binary write address for the dual-port RAM.
- Generates the Gray-coded write pointer that goes to the read-domain synchronizer.
- Produces registered full, almost-full, fill-level and sticky-overflow status from the read pointer, already synchronized into wr_clk.
- Counterpart of the read-side pointer block; the Gray encoding and pointer width must match it exactly.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_wr_ptr_ctrl.sv | 99 +++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO pointer blocks.
// Both the write-side and read-side pointer controllers use these functions.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

  // Functions work on 32 bits; zero-extended inputs convert correctly in their low bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer and status controller of the async FIFO (wr_clk domain).
// Define FIFO_WR_AFULL_EN to build the fill-level and almost-full logic.
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic                  wr_ovf_clr,
  input  logic [ADDR_WIDTH:0]   r2w_rd_ptr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  wr_full,
  output logic                  wr_afull,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_ovf
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 2 || AFULL_THRESH < 1 || AFULL_THRESH > 2 ** ADDR_WIDTH) begin : g_param_err
    $error("fifo_wr_ptr_ctrl: illegal ADDR_WIDTH/AFULL_THRESH");
  end

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gry_q, gry_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          wr_inc;
  logic [PW-1:0] full_cmp;

  always_comb begin
    wr_inc   = wr_en & ~full_q;
    bin_d    = bin_q + {{ADDR_WIDTH{1'b0}}, wr_inc};
    gry_d    = PW'(bin2gray(32'(bin_d)));
    // Full when the next write pointer is one lap ahead of the synchronized read pointer.
    full_cmp = {~r2w_rd_ptr[ADDR_WIDTH:ADDR_WIDTH-1], r2w_rd_ptr[ADDR_WIDTH-2:0]};
    full_d   = (gry_d == full_cmp);
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (wr_ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      bin_q  <= '0;
      gry_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gry_q  <= gry_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wr_addr = bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr  = gry_q;
  assign wr_full = full_q;
  assign wr_ovf  = ovf_q;

`ifdef FIFO_WR_AFULL_EN
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] level_q, level_d;
  logic          afull_q, afull_d;

  // Level uses the lagging read pointer, so it can only over-estimate the fill.
  always_comb begin
    rd_bin_s = PW'(gray2bin(32'(r2w_rd_ptr)));
    level_d  = bin_d - rd_bin_s;
    afull_d  = (32'(level_d) >= AFULL_THRESH);
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign wr_level = level_q;
  assign wr_afull = afull_q;
`else
  assign wr_level = '0;
  assign wr_afull = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Self-checking bench for fifo_wr_ptr_ctrl (ADDR_WIDTH=4, AFULL_THRESH=12).
// Expected outputs are queued by a reference model at drive time and compared after the edge.
module tb_fifo_wr_ptr_ctrl;

`ifdef FIFO_WR_AFULL_EN
  localparam bit AfullEn = 1'b1;
`else
  localparam bit AfullEn = 1'b0;
`endif

  logic       wr_clk = 1'b0;
  logic       wr_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_ovf_clr = 1'b0;
  logic [4:0] r2w_rd_ptr = '0;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr;
  logic       wr_full;
  logic       wr_afull;
  logic [4:0] wr_level;
  logic       wr_ovf;

  fifo_wr_ptr_ctrl #(
    .ADDR_WIDTH  (4),
    .AFULL_THRESH(12)
  ) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .wr_en     (wr_en),
    .wr_ovf_clr(wr_ovf_clr),
    .r2w_rd_ptr(r2w_rd_ptr),
    .wr_addr   (wr_addr),
    .wr_ptr    (wr_ptr),
    .wr_full   (wr_full),
    .wr_afull  (wr_afull),
    .wr_level  (wr_level),
    .wr_ovf    (wr_ovf)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_bin, m_gray, m_level;
  bit m_full, m_afull, m_ovf;
  int d1, d2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input int g);
    int b = 0;
    for (int i = 4; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  task automatic model_reset();
    m_bin = 0; m_gray = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
    sb_q.delete();
  endtask

  // Step the model with the inputs currently driven, then compare after the clock edge.
  task automatic cycle(input string tag);
    int   inc, nb, rdb, lvl;
    bit   nf, novf;
    exp_t e;
    inc  = (wr_en && !m_full) ? 1 : 0;
    nb   = (m_bin + inc) & 31;
    rdb  = from_gray(int'(r2w_rd_ptr));
    nf   = (to_gray(nb) == (int'(r2w_rd_ptr) ^ 32'h18));
    lvl  = (nb - rdb) & 31;
    novf = (wr_en && m_full) ? 1'b1 : (wr_ovf_clr ? 1'b0 : m_ovf);
    m_bin = nb; m_gray = to_gray(nb); m_full = nf; m_level = lvl;
    m_afull = (lvl >= 12); m_ovf = novf;
    e.addr  = 4'(m_bin);
    e.ptr   = 5'(m_gray);
    e.full  = m_full;
    e.afull = AfullEn ? m_afull : 1'b0;
    e.level = AfullEn ? 5'(m_level) : 5'd0;
    e.ovf   = m_ovf;
    sb_q.push_back(e);
    @(posedge wr_clk);
    #1;
    e = sb_q.pop_front();
    check_val({tag, "_addr"}, 32'(wr_addr), 32'(e.addr));
    check_val({tag, "_ptr"}, 32'(wr_ptr), 32'(e.ptr));
    check_val({tag, "_full"}, 32'(wr_full), 32'(e.full));
    check_val({tag, "_afull"}, 32'(wr_afull), 32'(e.afull));
    check_val({tag, "_level"}, 32'(wr_level), 32'(e.level));
    check_val({tag, "_ovf"}, 32'(wr_ovf), 32'(e.ovf));
  endtask

  task automatic do_reset();
    wr_en = 0; wr_ovf_clr = 0; r2w_rd_ptr = '0;
    wr_rst = 0;
    @(posedge wr_clk);
    #1;
    wr_rst = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    check_val("rst_addr", 32'(wr_addr), 0);
    check_val("rst_ptr", 32'(wr_ptr), 0);
    check_val("rst_full", 32'(wr_full), 0);
    @(posedge wr_clk);
    #1;
    wr_rst = 1;

    // Async reset mid-cycle after five writes.
    wr_en = 1;
    repeat (5) cycle("t1");
    check_val("t1_addr5", 32'(wr_addr), 5);
    wr_en = 0;
    #2;
    wr_rst = 0;
    r2w_rd_ptr = 5'b10110;
    #1;
    check_val("t1_arst_addr", 32'(wr_addr), 0);
    check_val("t1_arst_ptr", 32'(wr_ptr), 0);
    check_val("t1_arst_full", 32'(wr_full), 0);
    check_val("t1_arst_afull", 32'(wr_afull), 0);
    check_val("t1_arst_level", 32'(wr_level), 0);
    check_val("t1_arst_ovf", 32'(wr_ovf), 0);
    model_reset();
    @(posedge wr_clk);
    #1;
    r2w_rd_ptr = '0;
    wr_rst = 1;
    wr_en = 1;
    cycle("t1_first");
    check_val("t1_first_addr", 32'(wr_addr), 1);

    // Fill from empty with the read pointer parked at 0.
    do_reset();
    wr_en = 1;
    for (int i = 1; i <= 17; i++) begin
      cycle("t2");
      if (i == 11) begin
        check_val("t3_level11", 32'(wr_level), AfullEn ? 11 : 0);
        check_val("t3_afull11", 32'(wr_afull), 0);
      end
      if (i == 12) begin
        check_val("t3_level12", 32'(wr_level), AfullEn ? 12 : 0);
        check_val("t3_afull12", 32'(wr_afull), AfullEn ? 1 : 0);
      end
      if (i == 15) check_val("t2_addr15", 32'(wr_addr), 15);
      if (i == 16) begin
        check_val("t2_ptr16", 32'(wr_ptr), 32'h18);
        check_val("t2_full16", 32'(wr_full), 1);
        check_val("t2_ovf16", 32'(wr_ovf), 0);
      end
      if (i == 17) begin
        check_val("t2_ptr_hold", 32'(wr_ptr), 32'h18);
        check_val("t2_ovf17", 32'(wr_ovf), 1);
      end
    end
    wr_en = 0;

    // Release from full by one read-pointer step, then refill.
    r2w_rd_ptr = 5'b00001;
    cycle("t4_rel");
    check_val("t4_full_clr", 32'(wr_full), 0);
    check_val("t4_level15", 32'(wr_level), AfullEn ? 15 : 0);
    wr_en = 1;
    cycle("t4_wr");
    check_val("t4_ptr17", 32'(wr_ptr), 32'h19);
    check_val("t4_full_again", 32'(wr_full), 1);
    wr_en = 0;

    // Overflow flag: clear, set-wins-over-clear, clear again.
    wr_ovf_clr = 1;
    cycle("t6_clr");
    check_val("t6_ovf_clr", 32'(wr_ovf), 0);
    wr_en = 1;
    cycle("t6_both");
    check_val("t6_set_wins", 32'(wr_ovf), 1);
    wr_en = 0;
    cycle("t6_clr2");
    check_val("t6_ovf_clr2", 32'(wr_ovf), 0);
    wr_ovf_clr = 0;

    // Wrap-around with the read pointer trailing two cycles behind.
    do_reset();
    d1 = 0; d2 = 0;
    wr_en = 1;
    for (int i = 1; i <= 40; i++) begin
      r2w_rd_ptr = 5'(d2);
      cycle("t5");
      d2 = d1;
      d1 = m_gray;
      check_val("t5_nofull", 32'(wr_full), 0);
      if (i == 16) begin
        check_val("t5_msb16", 32'(wr_ptr[4]), 1);
        check_val("t5_wrap16", 32'(wr_addr), 0);
      end
      if (i == 32) begin
        check_val("t5_msb32", 32'(wr_ptr[4]), 0);
        check_val("t5_wrap32", 32'(wr_addr), 0);
      end
    end
    wr_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
